// File: rtl/tappy_pkg.sv
// Shared types and helpers for the PS/2 host transmitter (tappy_tx) and the device receiver.
package tappy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PRTY,
        STOP,
        WAITIDLE
    } state_t;

    typedef enum logic [1:0] {
        ERR_NOACK   = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_BUS     = 2'd2
    } err_code_t;

    // Device falling edges per host-to-device frame: 8 data, parity, stop, ACK.
    localparam int unsigned PS2_FRAME_FALLS = 11;
    localparam int unsigned FALL_CNT_W      = 4;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines, plus a {prev, cur}
// clock history that flags a falling edge three sysclk cycles after the line drops.
module ps2_sync (
    input  logic sysclk,
    input  logic reset,
    input  logic clk_in,
    input  logic dat_in,
    output logic clk_fall,
    output logic clk_s,
    output logic dat_s
);

    logic [1:0] clk_meta;
    logic [1:0] dat_meta;
    logic [1:0] clk_hist;

    // Flops reset to the idle-bus level so leaving reset never looks like an edge.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            clk_meta <= 2'b11;
            dat_meta <= 2'b11;
            clk_hist <= 2'b11;
        end else begin
            clk_meta <= {clk_meta[0], clk_in};
            dat_meta <= {dat_meta[0], dat_in};
            clk_hist <= {clk_hist[0], clk_meta[1]};
        end
    end

    assign clk_s    = clk_hist[0];
    assign dat_s    = dat_meta[1];
    assign clk_fall = (clk_hist == 2'b10);

endmodule

// File: rtl/tappy_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shift one byte
// out on device clock falls and check the ACK. Optional watchdog: TAPPY_TX_TIMEOUT_EN.
module tappy_tx
    import tappy_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int unsigned       CNT_W        = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [FALL_CNT_W-1:0] LAST_DATA_FALL = FALL_CNT_W'(PS2_FRAME_FALLS - 3);

    if (INHIBIT_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("tappy_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be non-zero");
    end

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [FALL_CNT_W-1:0] falls, falls_nxt;
    logic [8:0]            shreg, shreg_nxt;
    err_code_t             err_code_q, err_code_nxt;
    logic                  clk_oe_nxt, dat_oe_nxt;
    logic                  done_nxt, err_nxt, ready_nxt;

    logic clk_fall, clk_s, dat_s;

    ps2_sync u_sync (
        .sysclk   (sysclk),
        .reset    (reset),
        .clk_in   (ps2_clk_in),
        .dat_in   (ps2_dat_in),
        .clk_fall (clk_fall),
        .clk_s    (clk_s),
        .dat_s    (dat_s)
    );

`ifdef TAPPY_TX_TIMEOUT_EN
    localparam int unsigned      WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
    logic [WDOG_W-1:0] wdog, wdog_nxt;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) wdog <= '0;
        else       wdog <= wdog_nxt;
    end
`endif

    // Next-state and next-output decode; all outputs are registered from these.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        falls_nxt    = falls;
        shreg_nxt    = shreg;
        err_code_nxt = err_code_q;
        clk_oe_nxt   = 1'b0;
        dat_oe_nxt   = ps2_dat_oe;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
`ifdef TAPPY_TX_TIMEOUT_EN
        wdog_nxt     = '0;
`endif

        case (state)
            IDLE: begin
                dat_oe_nxt = 1'b0;
                cnt_nxt    = '0;
                if (tx_valid && tx_ready) begin
                    shreg_nxt  = {odd_parity(tx_byte), tx_byte};
                    falls_nxt  = '0;
                    clk_oe_nxt = 1'b1;
                    dat_oe_nxt = (INHIBIT_CYCLES == 1);
                    state_nxt  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == INHIBIT_LAST) begin
                    dat_oe_nxt = 1'b1;
                    state_nxt  = REQ;
                end else begin
                    cnt_nxt    = cnt + 1'b1;
                    clk_oe_nxt = 1'b1;
                    // start bit goes out in the last inhibit cycle
                    dat_oe_nxt = (cnt_nxt == INHIBIT_LAST);
                end
            end
            REQ, DATA: begin
                if (clk_fall) begin
                    dat_oe_nxt = ~shreg[0];
                    shreg_nxt  = {1'b0, shreg[8:1]};
                    falls_nxt  = falls + 1'b1;
                    state_nxt  = (falls == LAST_DATA_FALL) ? PRTY : DATA;
                end
            end
            PRTY: begin
                if (clk_fall) begin
                    dat_oe_nxt = 1'b0;
                    state_nxt  = STOP;
                end
            end
            STOP: begin
                if (clk_fall) begin
                    if (!dat_s) begin
                        state_nxt = WAITIDLE;
                    end else begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_NOACK;
                        state_nxt    = IDLE;
                    end
                end
            end
            WAITIDLE: begin
                if (clk_fall) begin
                    err_nxt      = 1'b1;
                    err_code_nxt = ERR_BUS;
                    state_nxt    = IDLE;
                end else if (clk_s && dat_s) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

`ifdef TAPPY_TX_TIMEOUT_EN
        // Watchdog runs from clock release until the ACK has been sampled.
        if (state inside {REQ, DATA, PRTY, STOP}) begin
            if (wdog == WDOG_LAST) begin
                clk_oe_nxt   = 1'b0;
                dat_oe_nxt   = 1'b0;
                err_nxt      = 1'b1;
                err_code_nxt = ERR_TIMEOUT;
                state_nxt    = IDLE;
            end else begin
                wdog_nxt = wdog + 1'b1;
            end
        end
`endif

        ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            falls      <= '0;
            shreg      <= '0;
            err_code_q <= ERR_NOACK;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            falls      <= falls_nxt;
            shreg      <= shreg_nxt;
            err_code_q <= err_code_nxt;
            ps2_clk_oe <= clk_oe_nxt;
            ps2_dat_oe <= dat_oe_nxt;
            tx_ready   <= ready_nxt;
            busy       <= ~ready_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
        end
    end

    assign err_code = err_code_q;

endmodule
